// File: rtl/jpeg_unstuff_pkg.sv
// Shared types and constants for the JPEG byte unstuffer.
// Optional statistics are enabled with JPEG_UNSTUFF_STATS_EN (see jpeg_byte_unstuffer).
package jpeg_unstuff_pkg;

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_FF   = 2'd1,
        S_EOI  = 2'd2
    } state_e;

    localparam logic [7:0] MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] STUFF_BYTE    = 8'h00;
    localparam logic [7:0] EOI_CODE      = 8'hD9;
    localparam logic [7:0] RST_MASK      = 8'hF8;
    localparam logic [7:0] RST_BASE      = 8'hD0;

    function automatic logic is_rst_marker(input logic [7:0] code);
        return (code & RST_MASK) == RST_BASE;
    endfunction

endpackage

// File: rtl/jpeg_byte_outreg.sv
// Byte-wide registered valid/accept output slice: load, hold until accepted, clear.
module jpeg_byte_outreg (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       accept_i,
    output logic       ready_o,
    output logic [7:0] data_o,
    output logic       valid_o
);

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    assign ready_o = !valid_q || accept_i;
    assign data_o  = data_q;
    assign valid_o = valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (accept_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/jpeg_byte_unstuffer.sv
// Splits FIFO words into bytes, removes FF00 stuffing and fill FFs, reports markers.
// Define JPEG_UNSTUFF_STATS_EN to add saturating stuff/fill counters.
module jpeg_byte_unstuffer
    import jpeg_unstuff_pkg::*;
#(
    parameter bit          BYTE_ORDER_LE = 1'b1,
    parameter int unsigned STAT_W        = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [31:0] data_in_i,
    input  logic        valid_i,
    output logic        pop_o,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        accept_i,
    output logic        marker_valid_o,
    output logic [7:0]  marker_o,
    output logic        eoi_o
`ifdef JPEG_UNSTUFF_STATS_EN
    ,
    output logic [STAT_W-1:0] stuff_cnt_o,
    output logic [STAT_W-1:0] fill_cnt_o
`endif
);

    logic [31:0] buf_q, buf_d;
    logic        buf_valid_q, buf_valid_d;
    logic [1:0]  idx_q, idx_d;
    state_e      state_q, state_d;
    logic        marker_valid_q, marker_valid_d;
    logic [7:0]  marker_q, marker_d;
    logic        eoi_q, eoi_d;

    logic [1:0]  sel;
    logic [7:0]  cur_byte;
    logic        emit;
    logic [7:0]  emit_byte;
    logic        is_marker;
    logic        is_eoi;
    state_e      byte_state;
    logic        out_ready;
    logic        consume;
    logic        pop;

    assign sel      = BYTE_ORDER_LE ? idx_q : (2'd3 - idx_q);
    assign cur_byte = buf_q[{sel, 3'b000} +: 8];

    // Per-byte decode; only acted upon when the byte is actually consumed.
    always_comb begin
        emit       = 1'b0;
        emit_byte  = cur_byte;
        is_marker  = 1'b0;
        is_eoi     = 1'b0;
        byte_state = state_q;
        unique case (state_q)
            S_DATA: begin
                if (cur_byte == MARKER_PREFIX) begin
                    byte_state = S_FF;
                end else begin
                    emit = 1'b1;
                end
            end
            S_FF: begin
                if (cur_byte == STUFF_BYTE) begin
                    emit       = 1'b1;
                    emit_byte  = MARKER_PREFIX;
                    byte_state = S_DATA;
                end else if (cur_byte == MARKER_PREFIX) begin
                    byte_state = S_FF;
                end else if (cur_byte == EOI_CODE) begin
                    is_marker  = 1'b1;
                    is_eoi     = 1'b1;
                    byte_state = S_EOI;
                end else if (is_rst_marker(cur_byte)) begin
                    is_marker  = 1'b1;
                    byte_state = S_DATA;
                end else begin
                    is_marker  = 1'b1;
                    byte_state = S_DATA;
                end
            end
            S_EOI:   byte_state = S_EOI;
            default: byte_state = S_DATA;
        endcase
    end

    assign consume = buf_valid_q && (state_q != S_EOI) && (!emit || out_ready);

    // After EOI every offered word is drained and dropped.
    assign pop = !flush_i && valid_i &&
                 ((state_q == S_EOI) || !buf_valid_q || ((idx_q == 2'd3) && consume));
    assign pop_o = pop;

    always_comb begin
        buf_d          = buf_q;
        buf_valid_d    = buf_valid_q;
        idx_d          = idx_q;
        state_d        = state_q;
        marker_valid_d = 1'b0;
        marker_d       = marker_q;
        eoi_d          = eoi_q;
        if (state_q == S_EOI) begin
            buf_valid_d = 1'b0;
        end else begin
            if (consume) begin
                idx_d   = idx_q + 2'd1;
                state_d = byte_state;
                if (idx_q == 2'd3) buf_valid_d = 1'b0;
                if (is_marker) begin
                    marker_valid_d = 1'b1;
                    marker_d       = cur_byte;
                end
                if (is_eoi) eoi_d = 1'b1;
            end
            if (pop) begin
                buf_d       = data_in_i;
                buf_valid_d = 1'b1;
                idx_d       = 2'd0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q          <= '0;
            buf_valid_q    <= 1'b0;
            idx_q          <= 2'd0;
            state_q        <= S_DATA;
            marker_valid_q <= 1'b0;
            marker_q       <= '0;
            eoi_q          <= 1'b0;
        end else if (flush_i) begin
            buf_q          <= '0;
            buf_valid_q    <= 1'b0;
            idx_q          <= 2'd0;
            state_q        <= S_DATA;
            marker_valid_q <= 1'b0;
            marker_q       <= '0;
            eoi_q          <= 1'b0;
        end else begin
            buf_q          <= buf_d;
            buf_valid_q    <= buf_valid_d;
            idx_q          <= idx_d;
            state_q        <= state_d;
            marker_valid_q <= marker_valid_d;
            marker_q       <= marker_d;
            eoi_q          <= eoi_d;
        end
    end

    assign marker_valid_o = marker_valid_q;
    assign marker_o       = marker_q;
    assign eoi_o          = eoi_q;

    jpeg_byte_outreg u_outreg (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .load_i   (consume && emit),
        .data_i   (emit_byte),
        .accept_i (accept_i),
        .ready_o  (out_ready),
        .data_o   (data_o),
        .valid_o  (valid_o)
    );

`ifdef JPEG_UNSTUFF_STATS_EN
    logic [STAT_W-1:0] stuff_cnt_q, fill_cnt_q;
    logic              stuff_hit, fill_hit;

    assign stuff_hit = consume && (state_q == S_FF) && (cur_byte == STUFF_BYTE);
    assign fill_hit  = consume && (state_q == S_FF) && (cur_byte == MARKER_PREFIX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stuff_cnt_q <= '0;
            fill_cnt_q  <= '0;
        end else if (flush_i) begin
            stuff_cnt_q <= '0;
            fill_cnt_q  <= '0;
        end else begin
            if (stuff_hit && (stuff_cnt_q != '1)) stuff_cnt_q <= stuff_cnt_q + STAT_W'(1);
            if (fill_hit && (fill_cnt_q != '1))   fill_cnt_q  <= fill_cnt_q + STAT_W'(1);
        end
    end

    assign stuff_cnt_o = stuff_cnt_q;
    assign fill_cnt_o  = fill_cnt_q;
`else
    logic [STAT_W-1:0] unused_stat;
    assign unused_stat = '0;
`endif

endmodule

// File: tb/tb_jpeg_byte_unstuffer.sv
// Self-checking bench for jpeg_byte_unstuffer: vector table plus multi-cycle sequences.
module tb_jpeg_byte_unstuffer;

    logic        clk;
    logic        rst_ni;
    logic        flush_i;
    logic [31:0] data_in_i;
    logic        valid_i;
    logic        pop_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        accept_i;
    logic        marker_valid_o;
    logic [7:0]  marker_o;
    logic        eoi_o;

    jpeg_byte_unstuffer #(
        .BYTE_ORDER_LE (1'b1),
        .STAT_W        (16)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .data_in_i      (data_in_i),
        .valid_i        (valid_i),
        .pop_o          (pop_o),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .accept_i       (accept_i),
        .marker_valid_o (marker_valid_o),
        .marker_o       (marker_o),
        .eoi_o          (eoi_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int unsigned nbytes;
        logic [31:0] bytes;   // expected output bytes, first byte in [7:0]
        int unsigned nmk;
        logic [7:0]  marker;
        logic        eoi;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] wq[$];
    logic [7:0]  sbq[$];
    int          pop_cyc[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pops     = 0;
    int          mk_cnt   = 0;
    int          cyc      = 0;
    logic        acc      = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: drive at +1 after posedge, sample at negedge, retire FIFO word on pop.
    task automatic step();
        logic did_pop;
        logic [7:0] e;
        valid_i   = (wq.size() != 0);
        data_in_i = valid_i ? wq[0] : 32'h0;
        accept_i  = acc;
        @(negedge clk);
        did_pop = pop_o;
        if (pop_o) begin
            check("pop_needs_valid", {31'b0, valid_i}, 32'd1);
            pops++;
            pop_cyc.push_back(cyc);
        end
        if (valid_o && accept_i) begin
            if (sbq.size() == 0) begin
                check("unexpected_byte", {24'b0, data_o}, 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                check("byte", {24'b0, data_o}, {24'b0, e});
            end
        end
        if (marker_valid_o) mk_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (did_pop) void'(wq.pop_front());
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        pops   = 0;
        mk_cnt = 0;
        pop_cyc.delete();
    endtask

    task automatic push_bytes(input logic [31:0] b, input int unsigned n);
        for (int k = 0; k < int'(n); k++) sbq.push_back(8'(b >> (8 * k)));
    endtask

    logic [7:0] held;

    initial begin
        rst_ni    = 1'b0;
        flush_i   = 1'b0;
        data_in_i = 32'h0;
        valid_i   = 1'b0;
        accept_i  = 1'b1;

        vecs[0] = '{32'h00FF3412, 3, 32'h00FF3412, 0, 8'h00, 1'b0};
        vecs[1] = '{32'hD0FFFFAA, 1, 32'h000000AA, 1, 8'hD0, 1'b0};
        vecs[2] = '{32'h55D9FF01, 1, 32'h00000001, 1, 8'hD9, 1'b1};
        vecs[3] = '{32'h12345678, 4, 32'h12345678, 0, 8'h00, 1'b0};
        vecs[4] = '{32'hFFC4FF00, 1, 32'h00000000, 1, 8'hC4, 1'b0};
        vecs[5] = '{32'h00FF00FF, 2, 32'h0000FFFF, 0, 8'h00, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_o", {31'b0, valid_o}, 32'd0);
        check("rst_data_o", {24'b0, data_o}, 32'd0);
        check("rst_marker_valid_o", {31'b0, marker_valid_o}, 32'd0);
        check("rst_marker_o", {24'b0, marker_o}, 32'd0);
        check("rst_eoi_o", {31'b0, eoi_o}, 32'd0);
        check("rst_pop_o", {31'b0, pop_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Single-word vectors, each from a freshly flushed state.
        for (int i = 0; i < 6; i++) begin
            do_flush();
            check($sformatf("v%0d_flush_marker_o", i), {24'b0, marker_o}, 32'd0);
            wq.push_back(vecs[i].word);
            push_bytes(vecs[i].bytes, vecs[i].nbytes);
            repeat (12) step();
            check($sformatf("v%0d_drained", i), sbq.size(), 32'd0);
            check($sformatf("v%0d_pops", i), pops, 32'd1);
            check($sformatf("v%0d_marker_pulses", i), mk_cnt, vecs[i].nmk);
            check($sformatf("v%0d_marker_o", i), {24'b0, marker_o}, {24'b0, vecs[i].marker});
            check($sformatf("v%0d_eoi_o", i), {31'b0, eoi_o}, {31'b0, vecs[i].eoi});
            sbq.delete();
        end

        // FF in byte 3 with its 00 in the next word.
        do_flush();
        wq.push_back(32'hFF000000);
        wq.push_back(32'h11223300);
        push_bytes(32'hFF000000, 4);
        push_bytes(32'h00112233, 3);
        repeat (16) step();
        check("split_drained", sbq.size(), 32'd0);
        check("split_pops", pops, 32'd2);
        check("split_marker_pulses", mk_cnt, 32'd0);
        sbq.delete();

        // EOI then trailing words drained; flush clears sticky EOI.
        do_flush();
        wq.push_back(32'h55D9FF01);
        wq.push_back(32'hAABBCCDD);
        wq.push_back(32'h01020304);
        push_bytes(32'h00000001, 1);
        repeat (16) step();
        check("eoi_drained", sbq.size(), 32'd0);
        check("eoi_pops", pops, 32'd3);
        check("eoi_fifo_empty", wq.size(), 32'd0);
        check("eoi_marker_o", {24'b0, marker_o}, 32'hD9);
        check("eoi_marker_pulses", mk_cnt, 32'd1);
        check("eoi_set", {31'b0, eoi_o}, 32'd1);
        do_flush();
        check("eoi_flush_clear", {31'b0, eoi_o}, 32'd0);
        wq.push_back(32'h000000AB);
        push_bytes(32'h000000AB, 4);
        repeat (10) step();
        check("post_eoi_resume", sbq.size(), 32'd0);
        sbq.delete();

        // Backpressure mid-word, then full rate.
        do_flush();
        wq.push_back(32'h44332211);
        wq.push_back(32'h88776655);
        wq.push_back(32'hCCBBAA99);
        push_bytes(32'h44332211, 4);
        push_bytes(32'h88776655, 4);
        push_bytes(32'hCCBBAA99, 4);
        repeat (3) step();
        acc  = 1'b0;
        held = data_o;
        check("bp_held_byte", {24'b0, held}, 32'h22);
        repeat (10) step();
        check("bp_data_stable", {24'b0, data_o}, {24'b0, held});
        check("bp_valid_held", {31'b0, valid_o}, 32'd1);
        check("bp_no_pop", pops, 32'd1);
        check("bp_no_loss", sbq.size(), 32'd11);
        acc = 1'b1;
        repeat (16) step();
        check("bp_drained", sbq.size(), 32'd0);
        check("bp_pops", pops, 32'd3);
        if (pop_cyc.size() == 3) check("bp_pop_spacing", pop_cyc[2] - pop_cyc[1], 32'd4);
        else check("bp_pop_count", pop_cyc.size(), 32'd3);
        sbq.delete();

        // Async reset with idx=2 in S_FF and a held marker code.
        do_flush();
        wq.push_back(32'h3333C4FF);
        wq.push_back(32'h2200FF11);
        push_bytes(32'h00113333, 3);
        repeat (7) step();
        check("pre_rst_marker_o", {24'b0, marker_o}, 32'hC4);
        check("pre_rst_data_o", {24'b0, data_o}, 32'h11);
        wq.delete();
        valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid_o", {31'b0, valid_o}, 32'd0);
        check("arst_data_o", {24'b0, data_o}, 32'd0);
        check("arst_marker_o", {24'b0, marker_o}, 32'd0);
        check("arst_marker_valid_o", {31'b0, marker_valid_o}, 32'd0);
        check("arst_eoi_o", {31'b0, eoi_o}, 32'd0);
        check("arst_pop_o", {31'b0, pop_o}, 32'd0);
        check("arst_drained", sbq.size(), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        pops   = 0;
        mk_cnt = 0;
        wq.push_back(32'h77665500);
        push_bytes(32'h77665500, 4);
        repeat (10) step();
        check("arst_restart_drained", sbq.size(), 32'd0);
        check("arst_restart_pops", pops, 32'd1);
        check("arst_restart_markers", mk_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
